// File: rtl/ks3_seq_mul_if.sv
// ks3_seq_mul_if: operand/result bus of the sequential GF(2) multiplier.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. The producer holds its payload stable
// while valid is high and ready is low. Ready may be asserted without valid.
//
//   in_valid  / in_ready   : operand pair a/b, master -> slave
//   out_valid / out_ready  : product d, slave -> master
//   abort                  : synchronous cancel of the current job (master -> slave)
//   busy                   : slave is running or holding a result
//
// Modports: slave = the multiplier, master = the operand source / result sink.
interface ks3_seq_mul_if #(
   parameter int DIGITS = 4
);
   localparam int N = 3 * DIGITS;
   localparam int W = 6 * DIGITS - 1;

   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         abort;
   logic         busy;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] d;

   modport slave (
      input  in_valid, a, b, abort, out_ready,
      output in_ready, busy, out_valid, d
   );

   modport master (
      output in_valid, a, b, abort, out_ready,
      input  in_ready, busy, out_valid, d
   );
endinterface

// File: rtl/ks3_seq_mul.sv
// ks3_seq_mul: sequential GF(2) polynomial multiplier (no reduction).
//
// Both N=3*DIGITS-bit operands are split into 3-bit digits. One 3x3 carry-less
// core is time-shared: each RUN cycle multiplies one digit pair (i, j) and
// XOR-accumulates the 5-bit partial product at bit offset 3*(i+j) into a
// W=6*DIGITS-1 bit accumulator. RUN lasts exactly DIGITS^2 cycles.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   bus          ks3_seq_mul_if slave modport (in/out handshakes, abort, busy, d)
//   dbg_state_o  current FSM state (0 IDLE, 1 RUN, 2 DONE)
module ks3_seq_mul #(
   parameter int DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   ks3_seq_mul_if.slave       bus,
   output logic [1:0]         dbg_state_o
);
   localparam int N  = 3 * DIGITS;
   localparam int W  = 6 * DIGITS - 1;
   localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q;
   logic [CW-1:0] i_q, j_q;
   logic [N-1:0]  a_q, b_q;
   logic [W-1:0]  acc_q, acc_d;
   logic [W-1:0]  d_q;
   logic          in_ready_q, busy_q, out_valid_q;

   logic [2:0]    a_dig, b_dig;
   logic [4:0]    pp;
   int            shamt;

   // 3x3 carry-less product: XOR of shifted copies of x for each set bit of y.
   function automatic logic [4:0] ks3(input logic [2:0] x, input logic [2:0] y);
      logic [4:0] r;
      r = '0;
      for (int k = 0; k < 3; k++) begin
         if (y[k]) r = r ^ ({2'b00, x} << k);
      end
      return r;
   endfunction

   always_comb begin
      a_dig = a_q[3*int'(i_q) +: 3];
      b_dig = b_q[3*int'(j_q) +: 3];
      pp    = ks3(a_dig, b_dig);
      shamt = 3 * (int'(i_q) + int'(j_q));
      acc_d = acc_q ^ (W'(pp) << shamt);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         d_q         <= '0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // abort wins over in_valid: no accept in a cycle with abort high
               if (bus.in_valid && !bus.abort) begin
                  a_q        <= bus.a;
                  b_q        <= bus.b;
                  acc_q      <= '0;
                  i_q        <= '0;
                  j_q        <= '0;
                  state_q    <= S_RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            S_RUN: begin
               if (bus.abort) begin
                  state_q    <= S_IDLE;
                  acc_q      <= '0;
                  i_q        <= '0;
                  j_q        <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  if (j_q == LAST) begin
                     j_q <= '0;
                     if (i_q == LAST) begin
                        // last digit pair: publish the completed product
                        i_q         <= '0;
                        state_q     <= S_DONE;
                        d_q         <= acc_d;
                        out_valid_q <= 1'b1;
                     end else begin
                        i_q <= i_q + 1'b1;
                     end
                  end else begin
                     j_q <= j_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (bus.abort || bus.out_ready) begin
                  state_q     <= S_IDLE;
                  acc_q       <= '0;
                  d_q         <= '0;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               d_q         <= '0;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid_q;
   assign bus.d         = d_q;
   assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_ks3_seq_mul.sv
// tb_ks3_seq_mul: bench for ks3_seq_mul with DIGITS=4 (N=12, W=23).
// Directed jobs with known products plus random jobs checked against a
// bit-serial carry-less multiply model.
module tb_ks3_seq_mul;
   localparam int DIGITS = 4;
   localparam int N = 3 * DIGITS;
   localparam int W = 6 * DIGITS - 1;
   localparam int LAT = DIGITS * DIGITS;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   ks3_seq_mul_if #(.DIGITS(DIGITS)) bus_if ();

   ks3_seq_mul #(.DIGITS(DIGITS)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .dbg_state_o (dbg_state)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Carry-less product: XOR a shifted copy of a for every set bit of b.
   function automatic logic [W-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < N; k++)
         if (b[k]) r = r ^ (W'(a) << k);
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic check_idle(input string tag);
      check({tag, "_in_ready"},  32'(bus_if.in_ready),  32'd1);
      check({tag, "_busy"},      32'(bus_if.busy),      32'd0);
      check({tag, "_out_valid"}, 32'(bus_if.out_valid), 32'd0);
      check({tag, "_d"},         32'(bus_if.d),         32'd0);
   endtask

   // Present a/b at a negedge; the following posedge is the accept edge.
   task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk);
      check("accept_in_ready", 32'(bus_if.in_ready), 32'd1);
      bus_if.in_valid = 1'b1;
      bus_if.a = a;
      bus_if.b = b;
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.a = N'($urandom);
      bus_if.b = N'($urandom);
   endtask

   // Full job: accept, wait for out_valid (latency checked), stall, then handshake.
   task automatic run_job(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [W-1:0] expected, input int stall, input bit noisy);
      int cyc;
      logic [W-1:0] d_seen;
      logic [W-1:0] e;
      exp_q.push_back(expected);
      accept(a, b);
      // now at the negedge after the accept edge (cycle count 0 in RUN)
      cyc = 0;
      while (!bus_if.out_valid && cyc < 100) begin
         if (noisy) begin
            bus_if.in_valid = 1'($urandom_range(0, 1));
            bus_if.a = N'($urandom);
            bus_if.b = N'($urandom);
         end
         @(negedge clk);
         cyc++;
      end
      bus_if.in_valid = 1'b0;
      check("latency", 32'(cyc), 32'(LAT));
      if (!bus_if.out_valid) begin
         void'(exp_q.pop_front());
         return;
      end
      d_seen = bus_if.d;
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         if (bus_if.d !== d_seen || !bus_if.out_valid || bus_if.in_ready) begin
            check("stall_stable", {9'd0, bus_if.d}, {9'd0, d_seen});
            check("stall_valid", 32'(bus_if.out_valid), 32'd1);
            check("stall_in_ready", 32'(bus_if.in_ready), 32'd0);
         end
      end
      if (stall > 0) check("stall_d_end", 32'(bus_if.d), 32'(d_seen));
      e = exp_q.pop_front();
      check("d", 32'(bus_if.d), 32'(e));
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check("post_in_ready", 32'(bus_if.in_ready), 32'd1);
      check("post_out_valid", 32'(bus_if.out_valid), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int cyc;
      logic [N-1:0] ra, rb;
      rst = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.a         = '0;
      bus_if.b         = '0;
      bus_if.abort     = 1'b0;
      bus_if.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset");
      check("reset_state", 32'(dbg_state), 32'd0);
      rst = 1'b0;

      // directed products
      run_job(12'h001, 12'h001, 23'h000001, 0, 0);
      run_job(12'h003, 12'h003, 23'h000005, 1, 0);
      run_job(12'hFFF, 12'h001, 23'h000FFF, 0, 1);
      run_job(12'h800, 12'h800, 23'h400000, 2, 0);
      run_job(12'hFFF, 12'hFFF, 23'h555555, 0, 0);
      // long stall then back-to-back jobs
      run_job(12'hA5C, 12'h3E1, clmul(12'hA5C, 12'h3E1), 10, 0);
      run_job(12'h123, 12'h456, clmul(12'h123, 12'h456), 0, 0);

      // abort on RUN cycle 7
      accept(12'hABC, 12'hDEF);
      repeat (6) @(negedge clk);
      check("abort_busy_before", 32'(bus_if.busy), 32'd1);
      bus_if.abort = 1'b1;
      @(negedge clk);
      bus_if.abort = 1'b0;
      check_idle("abort_run");
      run_job(12'h005, 12'h003, 23'h00000F, 0, 0);

      // abort wins over in_valid in IDLE
      @(negedge clk);
      bus_if.abort = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.a = 12'h001;
      bus_if.b = 12'h001;
      @(negedge clk);
      bus_if.abort = 1'b0;
      bus_if.in_valid = 1'b0;
      check_idle("abort_idle");

      // abort in DONE clears d
      accept(12'h00F, 12'h00F);
      cyc = 0;
      while (!bus_if.out_valid && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_done_valid", 32'(bus_if.out_valid), 32'd1);
      bus_if.abort = 1'b1;
      @(negedge clk);
      bus_if.abort = 1'b0;
      check_idle("abort_done");

      // asynchronous reset mid-RUN
      accept(12'hFFF, 12'hFFF);
      repeat (5) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_idle("async_rst");
      #1 rst = 1'b0;
      run_job(12'h007, 12'h007, 23'h000015, 0, 0);

      // random jobs with random stalls and in_valid noise during RUN
      for (int t = 0; t < 1000; t++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         run_job(ra, rb, clmul(ra, rb), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
